i2c_target_regfile: RTL

- I2C responder (target) fronting a small byte-wide register file.
- Samples the shared SCL/SDA lines, detects START and STOP, and matches the 7-bit address.
- Accepts a register-pointer byte followed by write data, or returns read data with pointer auto-increment.
- Counterpart to the I2C master on the same bus; local logic gets a write-notify port and a combinational read port.

---
 rtl/i2c_target_regfile.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target (7-bit address TGT_ADDR) fronting a NUM_REGS x 8 register file.
// Ports: CLK/RST (async, active-low); SCL_IN/SDA_IN raw bus levels;
//   SDA_OUT_EN open-drain pull-down; BUSY addressed-until-STOP;
//   WR_STROBE/WR_ADDR/WR_DATA write notify; HOST_ADDR/HOST_RDATA local read.
// Optional: define I2C_TGT_GLITCH_FILTER_EN for a 3-sample line filter.
`timescale 1ns/1ps
module i2c_target_regfile #(
    parameter logic [6:0] TGT_ADDR = 7'h50,
    parameter int         NUM_REGS = 16,
    parameter int         PTR_W    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SCL_IN,
    input  logic             SDA_IN,
    output logic             SDA_OUT_EN,
    output logic             BUSY,
    output logic             WR_STROBE,
    output logic [PTR_W-1:0] WR_ADDR,
    output logic [7:0]       WR_DATA,
    input  logic [PTR_W-1:0] HOST_ADDR,
    output logic [7:0]       HOST_RDATA
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // Synchronizers reset to the idle-bus level so reset
    // release never fabricates an edge.
    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       w_scl_s;
    logic       w_sda_s;
    logic       w_scl;
    logic       w_sda;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], SCL_IN};
            r_sda_sync <= {r_sda_sync[0], SDA_IN};
        end
    end

    assign w_scl_s = r_scl_sync[1];
    assign w_sda_s = r_sda_sync[1];

`ifdef I2C_TGT_GLITCH_FILTER_EN
    // Output follows the line only when the current and two
    // previous synced samples agree; otherwise it holds.
    logic [1:0] r_scl_hist;
    logic [1:0] r_sda_hist;
    logic       r_scl_flt;
    logic       r_sda_flt;

    assign w_scl = (w_scl_s == r_scl_hist[0] && w_scl_s == r_scl_hist[1])
                 ? w_scl_s : r_scl_flt;
    assign w_sda = (w_sda_s == r_sda_hist[0] && w_sda_s == r_sda_hist[1])
                 ? w_sda_s : r_sda_flt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_flt  <= 1'b1;
            r_sda_flt  <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], w_scl_s};
            r_sda_hist <= {r_sda_hist[0], w_sda_s};
            r_scl_flt  <= w_scl;
            r_sda_flt  <= w_sda;
        end
    end
`else
    assign w_scl = w_scl_s;
    assign w_sda = w_sda_s;
`endif

    logic r_scl_d;
    logic r_sda_d;
    logic r_rise_p;
    logic r_fall_p;
    logic w_start;
    logic w_stop;

    assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;

    // Edge flags are delayed one CLK: sampling and driving
    // happen on the CLK after the edge is seen.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_scl_d  <= 1'b1;
            r_sda_d  <= 1'b1;
            r_rise_p <= 1'b0;
            r_fall_p <= 1'b0;
        end else begin
            r_scl_d  <= w_scl;
            r_sda_d  <= w_sda;
            r_rise_p <= w_scl & ~r_scl_d;
            r_fall_p <= ~w_scl & r_scl_d;
        end
    end

    logic [7:0]       r_regs [NUM_REGS];
    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [7:0]       r_shift;
    logic [PTR_W-1:0] r_ptr;
    logic             r_oe;
    logic             r_busy;
    logic             r_rw;
    logic             r_ld;
    logic             r_wr_stb;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_data;

    state_t           w_state_n;
    logic [3:0]       w_cnt_n;
    logic [7:0]       w_shift_n;
    logic [PTR_W-1:0] w_ptr_n;
    logic             w_oe_n;
    logic             w_busy_n;
    logic             w_rw_n;
    logic             w_ld_n;
    logic             w_we;
    logic [7:0]       w_byte;
    logic [7:0]       w_rd_byte;
    logic [PTR_W-1:0] w_ptr_inc;

    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_rd_byte = r_regs[r_ptr];
    assign w_ptr_inc = r_ptr + 1'b1;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_shift_n = r_shift;
        w_ptr_n   = r_ptr;
        w_oe_n    = r_oe;
        w_busy_n  = r_busy;
        w_rw_n    = r_rw;
        w_ld_n    = r_ld;
        w_we      = 1'b0;
        if (w_start) begin
            w_state_n = ADDR;
            w_cnt_n   = 4'd0;
            w_oe_n    = 1'b0;
            w_ld_n    = 1'b0;
        end else if (w_stop) begin
            w_state_n = IDLE;
            w_busy_n  = 1'b0;
            w_oe_n    = 1'b0;
            w_ld_n    = 1'b0;
        end else begin
            unique case (r_state)
                IDLE, IGNORE: begin
                end
                ADDR: begin
                    if (r_rise_p) begin
                        w_shift_n = w_byte;
                        w_cnt_n   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_cnt_n = 4'd0;
                            if (w_byte[7:1] == TGT_ADDR) begin
                                w_busy_n  = 1'b1;
                                w_rw_n    = w_byte[0];
                                w_state_n = ADDR_ACK;
                            end else begin
                                w_state_n = IGNORE;
                            end
                        end
                    end
                end
                PTR: begin
                    if (r_rise_p) begin
                        w_shift_n = w_byte;
                        w_cnt_n   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_cnt_n   = 4'd0;
                            w_ptr_n   = w_byte[PTR_W-1:0];
                            w_state_n = PTR_ACK;
                        end
                    end
                end
                WDATA: begin
                    if (r_rise_p) begin
                        w_shift_n = w_byte;
                        w_cnt_n   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_cnt_n   = 4'd0;
                            w_we      = 1'b1;
                            w_ptr_n   = w_ptr_inc;
                            w_state_n = WDATA_ACK;
                        end
                    end
                end
                // First SCL fall asserts ACK, second one ends it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (r_fall_p) begin
                        if (!r_oe) begin
                            w_oe_n = 1'b1;
                        end else begin
                            w_oe_n  = 1'b0;
                            w_cnt_n = 4'd0;
                            if (r_state == ADDR_ACK && r_rw) begin
                                w_state_n = RDATA;
                                w_shift_n = w_rd_byte;
                                w_oe_n    = ~w_rd_byte[7];
                                w_cnt_n   = 4'd1;
                            end else if (r_state == ADDR_ACK) begin
                                w_state_n = PTR;
                            end else begin
                                w_state_n = WDATA;
                            end
                        end
                    end
                end
                // r_cnt counts bits already put on the bus.
                RDATA: begin
                    if (r_fall_p) begin
                        if (r_ld) begin
                            w_ld_n    = 1'b0;
                            w_shift_n = w_rd_byte;
                            w_oe_n    = ~w_rd_byte[7];
                            w_cnt_n   = 4'd1;
                        end else if (r_cnt == 4'd8) begin
                            w_oe_n    = 1'b0;
                            w_cnt_n   = 4'd0;
                            w_state_n = RDATA_ACK;
                        end else begin
                            w_oe_n    = ~r_shift[6];
                            w_shift_n = {r_shift[6:0], 1'b0};
                            w_cnt_n   = r_cnt + 4'd1;
                        end
                    end
                end
                // Every transmitted byte advances the pointer once;
                // a NACK adds nothing further and ends the read.
                RDATA_ACK: begin
                    if (r_rise_p) begin
                        w_ptr_n = w_ptr_inc;
                        if (!w_sda) begin
                            w_state_n = RDATA;
                            w_ld_n    = 1'b1;
                        end else begin
                            w_state_n = IGNORE;
                        end
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 8'h00;
            r_ptr     <= '0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
            r_ld      <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_shift  <= w_shift_n;
            r_ptr    <= w_ptr_n;
            r_oe     <= w_oe_n;
            r_busy   <= w_busy_n;
            r_rw     <= w_rw_n;
            r_ld     <= w_ld_n;
            r_wr_stb <= w_we;
            if (w_we) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_byte;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_we) begin
            r_regs[r_ptr] <= w_byte;
        end
    end

    assign SDA_OUT_EN = r_oe;
    assign BUSY       = r_busy;
    assign WR_STROBE  = r_wr_stb;
    assign WR_ADDR    = r_wr_addr;
    assign WR_DATA    = r_wr_data;
    assign HOST_RDATA = r_regs[HOST_ADDR];

endmodule
